seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. One shared digit decoder (4-bit DIN in, active-low 7-bit segment pattern out) serves all digits: this block owns the digit values and presents one digit per scan slot to the decoder. It registers the returned pattern and drives the active-low digit selects. It provides leading-zero blanking, per-digit blink, and a tear-free load handshake so game logic can post a new value at any time.

---
 rtl/seg7_scan_ctrl_if.sv | 27 ++
 rtl/seg7_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Bundle of display-side signals for the 7-segment scan controller.
// The master side is the game logic plus the shared digit decoder;
// the slave side is the scan controller itself.
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                  load;
    logic [4*NDIG-1:0]     value;
    logic [NDIG-1:0]       blink_en;
    logic                  lzb_en;
    logic                  ready;
    logic                  frame;
    logic [3:0]            dec_din;
    logic [6:0]            dec_nhex;
    logic [6:0]            nhex;
    logic [NDIG-1:0]       nsel;

    modport master (
        output load, value, blink_en, lzb_en, dec_nhex,
        input  ready, frame, dec_din, nhex, nsel
    );

    modport slave (
        input  load, value, blink_en, lzb_en, dec_nhex,
        output ready, frame, dec_din, nhex, nsel
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Holds a shadow/active pair of digit values so a new value posted at any
// time is only swapped in at a frame boundary, feeds one digit per slot to
// an external shared decoder and registers the returned pattern.
module seg7_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000,
    parameter int DEAD      = 2
) (
    input logic            clk,
    input logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD   = CW'(DEAD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [IW-1:0]      idx;
    logic [CW-1:0]      cnt;
    logic [BW-1:0]      blink_cnt;
    logic               phase;
    logic [4*NDIG-1:0]  shadow;
    logic [4*NDIG-1:0]  active;
    logic               pending;
    logic               frame_q;
    logic [6:0]         nhex_q;
    logic [NDIG-1:0]    nsel_q;

    logic [3:0]         digit;
    logic               lead_zero;
    logic               blank;
    logic [NDIG-1:0]    sel_next;
    logic               slot_end;
    logic               frame_end;

    // Current digit, blanking decision and next select pattern from the registers.
    always_comb begin
        digit     = active[4*int'(idx) +: 4];
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        lead_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (i >= int'(idx) && active[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
        blank = (bus.blink_en[idx] && phase) ||
                (bus.lzb_en && (idx != '0) && lead_zero);
        sel_next = '1;
        if (cnt >= CNT_DEAD) begin
            sel_next[idx] = 1'b0;
        end
    end

    // Slot timer and digit index walking 0..NDIG-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Free-running blink timer, toggling the blank phase each half-period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Load capture into the shadow copy and frame-boundary commit to active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_end;
            if (frame_end && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (bus.load && !pending) begin
                shadow  <= bus.value;
                pending <= 1'b1;
            end
        end
    end

    // Registered segment and digit-select drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nhex_q <= 7'h7F;
            nsel_q <= '1;
        end else begin
            nhex_q <= blank ? 7'h7F : bus.dec_nhex;
            nsel_q <= sel_next;
        end
    end

    assign bus.ready   = ~pending;
    assign bus.frame   = frame_q;
    assign bus.dec_din = digit;
    assign bus.nhex    = nhex_q;
    assign bus.nsel    = nsel_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: time-based reference model checked every
// cycle, a table of display vectors, and directed multi-cycle sequences.
module tb_seg7_scan_ctrl;
    localparam int NDIG      = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
    localparam int DEAD      = 1;
    localparam int FRAME_LEN = NDIG * SCAN_DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    seg7_scan_ctrl_if #(.NDIG(NDIG)) bus();

    seg7_scan_ctrl #(
        .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .DEAD(DEAD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Shared decoder model, active-low gfedcba.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    assign bus.dec_nhex = decode(bus.dec_din);

    // Reference model: cycles since reset, shown value, posted value.
    int          m_pos = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pending = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare all outputs.
    task automatic applyStimulus(input bit rstn_in, input bit load_in, input logic [15:0] value_in,
                                 input logic [3:0] blink_in, input bit lzb_in);
        int         cnt;
        int         idx;
        bit         phase;
        bit         blank;
        bit         frame_end;
        logic [3:0] exp_nsel;
        logic [6:0] exp_nhex;
        rst_n        = rstn_in;
        bus.load     = load_in;
        bus.value    = value_in;
        bus.blink_en = blink_in;
        bus.lzb_en   = lzb_in;
        frame_end    = 1'b0;
        exp_nsel     = 4'hF;
        exp_nhex     = 7'h7F;
        if (rstn_in) begin
            cnt       = m_pos % SCAN_DIV;
            idx       = (m_pos / SCAN_DIV) % NDIG;
            phase     = ((m_pos / BLINK_DIV) % 2) == 1;
            frame_end = (m_pos % FRAME_LEN) == (FRAME_LEN - 1);
            if (cnt >= DEAD) exp_nsel[idx] = 1'b0;
            blank = (blink_in[idx] && phase) ||
                    (lzb_in && idx != 0 && (m_active >> (4 * idx)) == 16'h0);
            exp_nhex = blank ? 7'h7F : decode(m_active[4*idx +: 4]);
        end
        @(posedge clk);
        if (!rstn_in) begin
            m_pos = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
        end else begin
            if (frame_end && m_pending) begin
                m_active = m_shadow; m_pending = 1'b0;
            end else if (load_in && !m_pending) begin
                m_shadow = value_in; m_pending = 1'b1;
            end
            m_pos++;
        end
        @(negedge clk);
        checkOutput("nsel", bus.nsel, exp_nsel);
        checkOutput("nhex", bus.nhex, exp_nhex);
        checkOutput("frame", bus.frame, frame_end);
        checkOutput("ready", bus.ready, !m_pending);
        checkOutput("dec_din", bus.dec_din, m_active[4*((m_pos / SCAN_DIV) % NDIG) +: 4]);
    endtask

    // Run idle cycles until a FRAME pulse is seen, bounded.
    task automatic waitFrame(input logic [3:0] blink_in, input bit lzb_in);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME_LEN && !seen; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, blink_in, lzb_in);
            seen = bus.frame;
        end
        checkOutput("frame_timeout", seen, 1);
    endtask

    typedef struct {
        logic [15:0]           value;
        bit                    lzb;
        logic [NDIG-1:0][6:0]  exp_nhex;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          first;
        bit          shown;
        int          lit_cnt;
        int          blank_cnt;
        logic [3:0]  sel_pat;
        bit          r_rst;
        bit          r_ld;
        logic [15:0] r_val;
        logic [3:0]  r_blink;
        bit          r_lzb;

        vecs[0] = '{16'h0050, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[1] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[2] = '{16'h0A07, 1'b1, {7'h7F, 7'h08, 7'h40, 7'h78}};
        vecs[3] = '{16'h0050, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}};
        vecs[4] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};

        // Reset held for three cycles
        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        checkOutput("rst_nsel", bus.nsel, 4'hF);
        checkOutput("rst_nhex", bus.nhex, 7'h7F);
        checkOutput("rst_ready", bus.ready, 1);

        // First digit-0 select two cycles after release
        first = -1;
        for (int i = 1; i <= 8 && first < 0; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
            if (bus.nsel == 4'b1110) first = i;
        end
        checkOutput("first_sel_latency", first, 2);

        // Mid-frame load, then a busy load that must be ignored
        applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
        checkOutput("load_ready_low", bus.ready, 0);
        applyStimulus(1'b1, 1'b1, 16'h9999, 4'h0, 1'b0);
        checkOutput("busy_dec_din", bus.dec_din, 0);
        waitFrame(4'h0, 1'b0);
        checkOutput("commit_ready_with_frame", bus.ready, 1);
        checkOutput("commit_digit0", bus.dec_din, 4);

        // Load posted in the commit cycle waits a full frame
        for (int i = 0; i < FRAME_LEN && (m_pos % FRAME_LEN) != FRAME_LEN - 1; i++)
            applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h5678, 4'h0, 1'b0);
        checkOutput("edge_load_frame", bus.frame, 1);
        checkOutput("edge_load_ready", bus.ready, 0);
        checkOutput("edge_load_old_digit", bus.dec_din, 4);
        waitFrame(4'h0, 1'b0);
        checkOutput("edge_load_commit", bus.dec_din, 8);

        // Reset while a load is pending discards it
        applyStimulus(1'b1, 1'b1, 16'hBEEF, 4'h0, 1'b0);
        checkOutput("pend_ready_low", bus.ready, 0);
        repeat (2) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        shown = 1'b0;
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
            if (bus.dec_din != 4'h0) shown = 1'b1;
        end
        checkOutput("pend_discarded", shown, 0);
        checkOutput("pend_ready_after", bus.ready, 1);

        // Table of display vectors, checked per lit digit over one frame
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, vecs[k].value, 4'h0, vecs[k].lzb);
            waitFrame(4'h0, vecs[k].lzb);
            for (int t = 0; t < FRAME_LEN; t++) begin
                applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, vecs[k].lzb);
                for (int d = 0; d < NDIG; d++) begin
                    sel_pat = 4'hF;
                    sel_pat[d] = 1'b0;
                    if (bus.nsel == sel_pat)
                        checkOutput($sformatf("vec%0d_digit%0d", k, d), bus.nhex, vecs[k].exp_nhex[d]);
                end
            end
        end

        // Blink digit 1 over four frames: alternating lit and blank frames
        lit_cnt = 0;
        blank_cnt = 0;
        for (int t = 0; t < 4 * FRAME_LEN; t++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 4'b0010, 1'b0);
            if (bus.nsel == 4'b1101) begin
                if (bus.nhex == 7'h30) lit_cnt++;
                if (bus.nhex == 7'h7F) blank_cnt++;
            end
        end
        checkOutput("blink_lit", lit_cnt, 6);
        checkOutput("blink_blank", blank_cnt, 6);

        // Randomized traffic against the model
        r_blink = 4'h0;
        r_lzb   = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom_range(0, 299) != 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_val = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) r_blink = 4'($urandom);
            if ($urandom_range(0, 39) == 0) r_lzb = 1'($urandom);
            applyStimulus(r_rst, r_ld, r_val, r_blink, r_lzb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
